// File: rtl/row_accum_sched.sv
// row_accum_sched: meters row chunks into the adder tree and sequences the accumulator clear/accumulate tags.
// Define ROW_SCHED_PERF_EN to add saturating perf counters (o_perf_rows, o_perf_stall, o_perf_gap).

module row_accum_sched #(
  parameter int NI       = 8,
  parameter int TREE_LAT = 3,
  parameter int ACC_LAT  = 4,
  parameter int LEN_W    = 8,
  parameter int ROW_W    = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [LEN_W-1:0]   i_cmd_len,
  input  logic [ROW_W-1:0]   i_cmd_row,
  output logic               o_cmd_ready,
  input  logic               i_data_valid,
  input  logic [NI*32-1:0]   i_data_in,
  output logic               o_data_ready,
  output logic [NI*32-1:0]   o_tree_data,
  output logic               o_tree_valid,
  output logic               o_acc_valid,
  output logic               o_acc_first,
  output logic               o_result_valid,
  output logic [ROW_W-1:0]   o_result_row,
  output logic               o_busy
`ifdef ROW_SCHED_PERF_EN
  ,
  output logic [31:0]        o_perf_rows,
  output logic [31:0]        o_perf_stall,
  output logic [31:0]        o_perf_gap
`endif
);

  localparam int GAP_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam int TAG_W = ROW_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_cmd_ready, r_data_ready;
  logic [LEN_W-1:0]   r_rem;
  logic [ROW_W-1:0]   r_row;
  logic               r_first;
  logic [GAP_W-1:0]   r_gap;
  logic [NI*32-1:0]   r_tree_data;
  logic               r_tree_valid;
  logic [TAG_W-1:0]   r_tag0;
  logic [TREE_LAT:0]  r_tl_v;
  logic [TAG_W-1:0]   r_tl_tag [TREE_LAT+1];
  logic [ACC_LAT-1:0] r_al_v;
  logic [ROW_W-1:0]   r_al_row [ACC_LAT];
  logic               w_cmd_hs, w_data_hs, w_last, w_acc_last, w_busy;

  // Next-state decode; GAP spaces same-row chunks so accumulator feedback has settled.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_hs    = i_cmd_valid & r_cmd_ready;
    w_data_hs   = i_data_valid & r_data_ready;
    w_last      = (r_rem <= LEN_W'(1));
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) w_state_nxt = S_ISSUE;
        else          w_state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        if (w_data_hs) begin
          if (w_last)           w_state_nxt = S_IDLE;
          else if (ACC_LAT > 1) w_state_nxt = S_GAP;
          else                  w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_GAP: begin
        if (r_gap <= GAP_W'(1)) w_state_nxt = S_ISSUE;
        else                    w_state_nxt = S_GAP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, chunk metering and the tree-input register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_data_ready <= 1'b0;
      r_rem        <= {LEN_W{1'b0}};
      r_row        <= {ROW_W{1'b0}};
      r_first      <= 1'b0;
      r_gap        <= {GAP_W{1'b0}};
      r_tree_data  <= {(NI*32){1'b0}};
      r_tree_valid <= 1'b0;
      r_tag0       <= {TAG_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_cmd_ready  <= (w_state_nxt == S_IDLE);
      r_data_ready <= (w_state_nxt == S_ISSUE);
      if (w_cmd_hs) begin
        // A zero length is illegal; run it as a single-chunk row.
        r_rem   <= (i_cmd_len == {LEN_W{1'b0}}) ? LEN_W'(1) : i_cmd_len;
        r_row   <= i_cmd_row;
        r_first <= 1'b1;
      end else if (w_data_hs) begin
        r_rem   <= r_rem - LEN_W'(1);
        r_first <= 1'b0;
      end else begin
        r_rem   <= r_rem;
        r_first <= r_first;
      end
      if (r_state == S_GAP)  r_gap <= r_gap - GAP_W'(1);
      else if (w_data_hs)    r_gap <= GAP_W'(ACC_LAT - 1);
      else                   r_gap <= r_gap;
      r_tree_valid <= w_data_hs;
      r_tag0       <= w_data_hs ? {r_first, w_last, r_row} : {TAG_W{1'b0}};
      if (w_data_hs) r_tree_data <= i_data_in;
      else           r_tree_data <= r_tree_data;
    end
  end

  // Tag-only delay lines tracking the tree and accumulator latencies.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i <= TREE_LAT; i++) begin
        r_tl_v[i]   <= 1'b0;
        r_tl_tag[i] <= {TAG_W{1'b0}};
      end
      for (int j = 0; j < ACC_LAT; j++) begin
        r_al_v[j]   <= 1'b0;
        r_al_row[j] <= {ROW_W{1'b0}};
      end
    end else begin
      r_tl_v[0]   <= r_tree_valid;
      r_tl_tag[0] <= r_tag0;
      for (int i = 1; i <= TREE_LAT; i++) begin
        r_tl_v[i]   <= r_tl_v[i-1];
        r_tl_tag[i] <= r_tl_tag[i-1];
      end
      r_al_v[0]   <= w_acc_last;
      r_al_row[0] <= r_tl_tag[TREE_LAT][ROW_W-1:0];
      for (int j = 1; j < ACC_LAT; j++) begin
        r_al_v[j]   <= r_al_v[j-1];
        r_al_row[j] <= r_al_row[j-1];
      end
    end
  end

  // Busy covers the FSM and every tag still travelling through either line.
  always_comb begin
    w_busy = 1'b0;
    w_busy = (r_state != S_IDLE) | r_tree_valid | (|r_tl_v) | (|r_al_v);
  end

  assign w_acc_last     = r_tl_v[TREE_LAT] & r_tl_tag[TREE_LAT][TAG_W-2];
  assign o_cmd_ready    = r_cmd_ready;
  assign o_data_ready   = r_data_ready;
  assign o_tree_data    = r_tree_data;
  assign o_tree_valid   = r_tree_valid;
  assign o_acc_valid    = r_tl_v[TREE_LAT];
  assign o_acc_first    = r_tl_v[TREE_LAT] & r_tl_tag[TREE_LAT][TAG_W-1];
  assign o_result_valid = r_al_v[ACC_LAT-1];
  assign o_result_row   = r_al_row[ACC_LAT-1];
  assign o_busy         = w_busy;

`ifdef ROW_SCHED_PERF_EN
  logic [31:0] r_perf_rows, r_perf_stall, r_perf_gap;

  // Saturating event counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_rows  <= 32'd0;
      r_perf_stall <= 32'd0;
      r_perf_gap   <= 32'd0;
    end else begin
      if (o_result_valid && (r_perf_rows != 32'hFFFF_FFFF)) r_perf_rows <= r_perf_rows + 32'd1;
      else                                                  r_perf_rows <= r_perf_rows;
      if ((r_state == S_ISSUE) && !i_data_valid && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
      else
        r_perf_stall <= r_perf_stall;
      if ((r_state == S_GAP) && (r_perf_gap != 32'hFFFF_FFFF)) r_perf_gap <= r_perf_gap + 32'd1;
      else                                                     r_perf_gap <= r_perf_gap;
    end
  end

  assign o_perf_rows  = r_perf_rows;
  assign o_perf_stall = r_perf_stall;
  assign o_perf_gap   = r_perf_gap;
`endif

endmodule
